// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg
//   Shared types and constants for the operand entry controller:
//   entry-FSM state encoding, 7-segment constants and the nibble-to-segment
//   helper used by every HEX display.
//   Segment bytes are active-low: bit0 = seg a ... bit6 = seg g, bit7 = dp.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    S_A      = 2'd0,
    S_B      = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digits 0..F; dp is off (bit7 = 1) in every entry.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // dp = 1 lights the decimal point (drives bit7 low).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
    logic [7:0] seg;
    seg    = SEG_TABLE[nibble];
    seg[7] = ~dp;
    return seg;
  endfunction

endpackage

// File: rtl/operand_entry_ctrl_debounce.sv
// key_debounce
//   Synchronizes one active-low pushbutton, debounces it and emits a
//   single-cycle press pulse when the debounced level falls 1 -> 0.
//   Ports:
//     clk   - clock
//     rst   - asynchronous active-high reset (level forced to "released")
//     key   - raw active-low key input
//     press - one-cycle pulse on an accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          armed;
  logic [1:0]    valid_sr;
  logic [CW-1:0] cnt;

  // valid_sr marks when sync2 holds a real sample rather than its reset
  // value. The key is only armed once a real "released" sample is seen, so
  // a key held through reset never produces a press until released and
  // pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      valid_sr <= 2'b00;
      armed    <= 1'b0;
      stable   <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      valid_sr <= {valid_sr[0], 1'b1};
      press    <= 1'b0;
      if (valid_sr[1] && sync2) begin
        armed <= 1'b1;
      end
      if (!armed || (sync2 == stable)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Nth consecutive differing cycle: accept the new level. A flip away
        // from 1 is a press; a flip back to 1 (release) is silent.
        stable <= sync2;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl
//   Two-operand entry front end: KEY[0] (enter) latches A, then B and the
//   9-bit sum R; KEY[1] (clear) returns to entering A. Drives LEDR and
//   HEX0..HEX5 from a registered output stage one cycle behind the FSM.
//   Ports:
//     CLOCK_50   - system clock
//     RST        - asynchronous active-high reset
//     SW         - operand switches, sampled live
//     KEY        - active-low keys, [0] = enter, [1] = clear
//     LEDR       - [7:0] value, [8] carry, [9] result-shown flag
//     HEX0..HEX5 - active-low 7-seg: HEX1:0 operand A/live SW,
//                  HEX3:2 operand B, HEX5:4 sum (HEX4 dp = carry)
module operand_entry_ctrl
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [1:0]          KEY,
  output logic [9:0]          LEDR,
  output logic [7:0]          HEX0,
  output logic [7:0]          HEX1,
  output logic [7:0]          HEX2,
  output logic [7:0]          HEX3,
  output logic [7:0]          HEX4,
  output logic [7:0]          HEX5
);

  logic press_enter;
  logic press_clear;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clk   (CLOCK_50),
    .rst   (RST),
    .key   (KEY[0]),
    .press (press_enter)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk   (CLOCK_50),
    .rst   (RST),
    .key   (KEY[1]),
    .press (press_clear)
  );

  state_t              state_q, state_d;
  logic [SW_WIDTH-1:0] a_q, a_d;
  logic [SW_WIDTH-1:0] b_q, b_d;
  logic [SW_WIDTH:0]   r_q, r_d;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  // Clear is checked first so it wins over a simultaneous enter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    if (press_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
    end else if (press_enter) begin
      case (state_q)
        S_A: begin
          a_d     = SW;
          state_d = S_B;
        end
        S_B: begin
          b_d     = SW;
          r_d     = {1'b0, a_q} + {1'b0, SW};
          state_d = S_RESULT;
        end
        default: begin
          state_d = S_A;
          a_d     = '0;
          b_d     = '0;
          r_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      LEDR <= '0;
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
    end else begin
      case (state_q)
        S_A: begin
          LEDR <= {2'b00, SW[7:0]};
          HEX0 <= hex_to_seg(SW[3:0], 1'b0);
          HEX1 <= hex_to_seg(SW[7:4], 1'b0);
          HEX2 <= SEG_BLANK;
          HEX3 <= SEG_BLANK;
          HEX4 <= SEG_BLANK;
          HEX5 <= SEG_BLANK;
        end
        S_B: begin
          LEDR <= {2'b00, SW[7:0]};
          HEX0 <= hex_to_seg(a_q[3:0], 1'b0);
          HEX1 <= hex_to_seg(a_q[7:4], 1'b0);
          HEX2 <= SEG_BLANK;
          HEX3 <= SEG_BLANK;
          HEX4 <= SEG_BLANK;
          HEX5 <= SEG_BLANK;
        end
        default: begin
          LEDR <= {1'b1, r_q[8:0]};
          HEX0 <= hex_to_seg(a_q[3:0], 1'b0);
          HEX1 <= hex_to_seg(a_q[7:4], 1'b0);
          HEX2 <= hex_to_seg(b_q[3:0], 1'b0);
          HEX3 <= hex_to_seg(b_q[7:4], 1'b0);
          HEX4 <= hex_to_seg(r_q[3:0], r_q[8]);
          HEX5 <= hex_to_seg(r_q[7:4], 1'b0);
        end
      endcase
    end
  end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
Board-level controller that sequences two-operand entry from SW[7:0] using the active-low KEY pushbuttons. It adds the operands and drives LEDR and HEX0..HEX5 with the operands, the sum and the entry state. It is the sequential front end for the lab1 switch/LED/7-seg datapath: it debounces the keys, runs the entry FSM and schedules what each display shows.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key change (10 ms at 50 MHz); the bench uses 4.
SW_WIDTH, 8, operand width taken from SW.

Ports:
CLOCK_50  input  1  system clock; every register is clocked on its rising edge.
RST  input  1  asynchronous, active-high reset.
SW  input  8  operand switches, sampled live.
KEY  input  2  pushbuttons, active-low. KEY[0] = enter, KEY[1] = clear.
LEDR  output  10  status and value LEDs.
HEX0..HEX5  output  8 each  7-seg displays. Active-low; bit0 = seg a … bit6 = seg g, bit7 = dp.

Behaviour:
- Reset (RST high, async): FSM to S_A; A, B, R cleared; debounce state forced to "released". LEDR = 0, HEX0..HEX5 = 8'hFF (blank). All outputs are registered.
- Key path, per key:
  - 2-FF synchronizer, reset value 1.
  - The stable level flips only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - press = one-cycle pulse when the stable level goes 1->0. Release produces nothing.
  - A key held low produces exactly one pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
  - Latency: press is high in cycle DEBOUNCE_CYCLES+2, counted in rising edges after KEY is first sampled low.
- FSM states: S_A (entering A), S_B (entering B), S_RESULT.
  - press0 in S_A: A <= SW, go to S_B.
  - press0 in S_B: B <= SW, R <= {1'b0,A} + {1'b0,SW} (9 bits, carry in R[8]), go to S_RESULT.
  - press0 in S_RESULT: clear A, B, R; go to S_A.
  - press1 in any state: clear A, B, R; go to S_A.
  - press0 and press1 in the same cycle: press1 wins.
- Output schedule, registered one cycle after the state/data update:
  - LEDR[7:0]: live SW in S_A and S_B; R[7:0] in S_RESULT.
  - LEDR[8]: R[8] in S_RESULT, else 0.
  - LEDR[9]: 1 only in S_RESULT.
  - HEX1:HEX0: live SW in S_A; latched A otherwise.
  - HEX3:HEX2: latched B in S_RESULT; blank otherwise.
  - HEX5:HEX4: R[7:0] in S_RESULT; blank otherwise. HEX4 dp lit (bit7 = 0) iff R[8] = 1.
  - Hex digit encodings: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. Blank = FF.
- Mid-debounce reset: counter cleared, no pulse after RST drops, even if KEY is still low. The key must be released and pressed again.
- Sum wrap: 8'hFF + 8'hFF = 9'h1FE, giving R[7:0] = FE with carry set. No saturation.

Decomposition:
- Package operand_entry_pkg holds:
  - the state enum (S_A, S_B, S_RESULT);
  - SEG_BLANK = 8'hFF;
  - the 16-entry segment constant table;
  - function hex_to_seg(nibble, dp).
- Sub-module key_debounce (synchronizer + counter + falling-edge pulse), instantiated once per KEY bit. DEBOUNCE_CYCLES is passed through.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset: pulse RST, check asynchronously before the next edge -> LEDR = 000, HEX0..5 = FF. With SW = 3C, one cycle after release -> HEX1 = B0, HEX0 = C6, LEDR[7:0] = 3C.
2. SW = 3C, KEY = 2'b10 held for 10 cycles -> exactly one press0, high in cycle 6; state S_B. Set SW = E7 -> LEDR[7:0] tracks E7, HEX1/HEX0 stay B0/C6, HEX3..5 = FF.
3. From S_B with A = 3C, SW = E7, press KEY0 -> S_RESULT, with:
   - LEDR = 10'h323 (LEDR[9] = 1, carry = 1, R[7:0] = 23);
   - HEX5 = A4, HEX4 = 30 (dp lit);
   - HEX3 = 86, HEX2 = F8.
4. Bounce: KEY0 low 2 cycles, high 1, low 2, then high -> no press pulse, state and outputs unchanged.
5. Clear and priority:
   - In S_B, press KEY1 -> S_A, HEX2..5 = FF.
   - Drive KEY = 2'b00 in the same cycle -> press1 wins, state S_A, A/B/R = 0.
6. Reset mid-debounce: KEY0 low, RST pulsed at cycle 3 of the count -> no pulse ever while KEY stays low. Release then press again -> normal S_A -> S_B transition.
